// File: rtl/fifo_sched_pkg.sv
// Shared types and constants for the FIFO scheduler.
// Optional feature macro (handled in fifo_rr_arbiter): FIFO_SCHED_PRIO0_EN.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    RESET_PROG = 2'd0,
    RUN        = 2'd1,
    DRAIN      = 2'd2,
    PROG       = 2'd3
  } state_e;

  localparam int SKID_DEPTH = 2;

  function automatic int occ_width(input int entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus the next search start.
// FIFO_SCHED_PRIO0_EN gives requester 0 fixed top priority; the rest stay round-robin.
module fifo_rr_arbiter
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [PTR_W-1:0]   next_ptr_o
);

  logic [NUM_REQ-1:0] cand;
  logic               found;
  logic [PTR_W-1:0]   idx;

  always_comb begin
    cand       = valid_i;
    grant_o    = '0;
    next_ptr_o = ptr_i;
    found      = 1'b0;
    idx        = '0;
`ifdef FIFO_SCHED_PRIO0_EN
    // Requester 0 wins outright and leaves the rotation pointer for the others untouched.
    cand[0] = 1'b0;
    if (valid_i[0]) begin
      grant_o[0] = 1'b1;
      found      = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && cand[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        next_ptr_o   = PTR_W'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_sched.sv
// Scheduler in front of the synchronous FIFO: write arbitration, read skid buffer, offset programming.
// Build option FIFO_SCHED_PRIO0_EN selects fixed priority for requester 0 (see fifo_rr_arbiter).
module fifo_sched
  import fifo_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int FIFO_ENTRIES = 1024,
  parameter int RST_OFFSET   = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [DATA_WIDTH-1:0]               cfg_offset_i,
  input  logic                                cfg_load_i,
  output logic                                cfg_busy_o,
  output logic                                wr_o,
  output logic                                daf_o,
  output logic [DATA_WIDTH-1:0]               data_in_o,
  output logic                                rd_o,
  output logic                                oe_o,
  input  logic [DATA_WIDTH-1:0]               data_out_i,
  input  logic                                fifo_empty_i,
  input  logic                                fifo_full_i,
  input  logic                                half_full_i,
  input  logic                                af_ae_i,
  output logic                                rd_valid_o,
  output logic [DATA_WIDTH-1:0]               rd_data_o,
  input  logic                                rd_ready_i,
  output logic [occ_width(FIFO_ENTRIES)-1:0]  occupancy_o
);

  localparam int               OCC_W   = occ_width(FIFO_ENTRIES);
  localparam int               PTR_W   = $clog2(NUM_REQ);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_ENTRIES);

  state_e                 state_q;
  logic                   boot_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_nxt;
  logic [NUM_REQ-1:0]     grant;
  logic                   wr_open;
  logic                   hs;
  logic [DATA_WIDTH-1:0]  wdata;
  logic                   wr_q;
  logic                   daf_q;
  logic [DATA_WIDTH-1:0]  data_in_q;
  logic [DATA_WIDTH-1:0]  offset_q;

  logic [OCC_W-1:0]       occ_q, occ_d;
  logic                   rd_en;
  logic                   rd_q;
  logic                   pop;
  logic [1:0]             skid_cnt_q, skid_cnt_d;
  logic [1:0]             skid_left;
  logic [2:0]             skid_load;
  logic [DATA_WIDTH-1:0]  skid_q [SKID_DEPTH];
  logic [DATA_WIDTH-1:0]  skid_d [SKID_DEPTH];

  logic                   unused_flags;
  assign unused_flags = half_full_i ^ af_ae_i;

  fifo_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .valid_i    (req_valid_i),
    .ptr_i      (ptr_q),
    .grant_o    (grant),
    .next_ptr_o (ptr_nxt)
  );

  assign wr_open     = (state_q == RUN) && !fifo_full_i && (occ_q < OCC_MAX);
  assign req_ready_o = wr_open ? grant : '0;
  assign hs          = |req_ready_o;

  always_comb begin
    wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) wdata = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // RESET_PROG spans reset plus one visible cycle; boot_q marks the cycle that strobes daf.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= RESET_PROG;
      boot_q    <= 1'b1;
      ptr_q     <= '0;
      wr_q      <= 1'b0;
      daf_q     <= 1'b0;
      data_in_q <= '0;
      offset_q  <= '0;
    end else begin
      wr_q  <= hs;
      daf_q <= 1'b0;
      if (hs) begin
        data_in_q <= wdata;
        ptr_q     <= ptr_nxt;
      end
      case (state_q)
        RESET_PROG: begin
          boot_q <= 1'b0;
          if (boot_q) begin
            daf_q     <= 1'b1;
            data_in_q <= DATA_WIDTH'(RST_OFFSET);
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (cfg_load_i) begin
            offset_q <= cfg_offset_i;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (!wr_q) begin
            state_q   <= PROG;
            daf_q     <= 1'b1;
            data_in_q <= offset_q;
          end
        end
        PROG:    state_q <= RUN;
        default: state_q <= RESET_PROG;
      endcase
    end
  end

  assign cfg_busy_o = (state_q != RUN);
  assign wr_o       = wr_q;
  assign daf_o      = daf_q;
  assign data_in_o  = data_in_q;

  // Counting the slot freed by this cycle's pop keeps reads at one per cycle while the consumer is ready.
  assign pop        = rd_valid_o && rd_ready_i;
  assign skid_left  = skid_cnt_q - {1'b0, pop};
  assign skid_load  = {1'b0, skid_left} + {2'b0, rd_q};
  assign rd_en      = ((state_q == RUN) || (state_q == DRAIN)) && !fifo_empty_i
                      && (skid_load < 3'(SKID_DEPTH));
  assign rd_o       = rd_en;
  assign oe_o       = rd_en;

  always_comb begin
    occ_d = occ_q;
    if (hs && !rd_en) begin
      if (occ_q != OCC_MAX) occ_d = occ_q + 1'b1;
    end else if (!hs && rd_en) begin
      if (occ_q != '0) occ_d = occ_q - 1'b1;
    end
  end

  always_comb begin
    skid_d     = skid_q;
    skid_cnt_d = skid_left + {1'b0, rd_q};
    if (pop) skid_d[0] = skid_q[1];
    if (rd_q) skid_d[skid_left[0]] = data_out_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q      <= '0;
      rd_q       <= 1'b0;
      skid_cnt_q <= '0;
      skid_q     <= '{default: '0};
    end else begin
      occ_q      <= occ_d;
      rd_q       <= rd_en;
      skid_cnt_q <= skid_cnt_d;
      skid_q     <= skid_d;
    end
  end

  assign occupancy_o = occ_q;
  assign rd_valid_o  = (skid_cnt_q != '0);
  assign rd_data_o   = skid_q[0];

endmodule

// File: tb/tb_fifo_sched.sv
// Self-checking bench for fifo_sched with a behavioural FIFO model and a pop scoreboard.
// Expectations follow FIFO_SCHED_PRIO0_EN when the bench is built with it.
module tb_fifo_sched;
  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int ENT = 1024;
  localparam int OW  = 11;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NR-1:0]     req_valid_i;
  logic [NR*DW-1:0]  req_data_i;
  logic [NR-1:0]     req_ready_o;
  logic [DW-1:0]     cfg_offset_i;
  logic              cfg_load_i;
  logic              cfg_busy_o;
  logic              wr_o, daf_o, rd_o, oe_o;
  logic [DW-1:0]     data_in_o;
  logic [DW-1:0]     data_out_i;
  logic              fifo_empty_i, fifo_full_i;
  logic              half_full_i = 1'b0;
  logic              af_ae_i = 1'b0;
  logic              rd_valid_o;
  logic [DW-1:0]     rd_data_o;
  logic              rd_ready_i;
  logic [OW-1:0]     occupancy_o;
  logic [DW-1:0]     req_data [NR];

  assign req_data_i = {req_data[3], req_data[2], req_data[1], req_data[0]};

  fifo_sched dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .cfg_offset_i(cfg_offset_i), .cfg_load_i(cfg_load_i),
    .cfg_busy_o(cfg_busy_o), .wr_o(wr_o), .daf_o(daf_o), .data_in_o(data_in_o),
    .rd_o(rd_o), .oe_o(oe_o), .data_out_i(data_out_i), .fifo_empty_i(fifo_empty_i),
    .fifo_full_i(fifo_full_i), .half_full_i(half_full_i), .af_ae_i(af_ae_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_ready_i(rd_ready_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] fq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural synchronous FIFO: one-cycle read latency, registered flags.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fq.delete();
      fifo_empty_i <= 1'b1;
      fifo_full_i  <= 1'b0;
      data_out_i   <= '0;
    end else begin
      if (rd_o && fq.size() > 0) data_out_i <= fq.pop_front();
      if (wr_o && !daf_o) fq.push_back(data_in_o);
      fifo_empty_i <= (fq.size() == 0);
      fifo_full_i  <= (fq.size() >= ENT);
    end
  end

  logic [DW-1:0] exp_d;
  always @(negedge clk_i) begin
    if (!rst_i && rd_valid_o && rd_ready_i) begin
      if (exp_q.size() == 0) chk("pop_extra", 32'(rd_data_o), 32'hFFFF_FFFF);
      else begin
        exp_d = exp_q.pop_front();
        chk("pop_data", 32'(rd_data_o), 32'(exp_d));
      end
    end
  end

  typedef struct {
    logic [NR-1:0] valid;
    logic [NR-1:0] exp_ready;
  } vec_t;
  vec_t tbl [15];

  task automatic set_vec(input int i, input logic [3:0] v, input logic [3:0] e_rr, input logic [3:0] e_p0);
    tbl[i].valid = v;
`ifdef FIFO_SCHED_PRIO0_EN
    tbl[i].exp_ready = e_p0;
`else
    tbl[i].exp_ready = e_rr;
`endif
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    int r = 0;
    for (int b = 0; b < NR; b++) if (v[b]) r = b;
    return r;
  endfunction

  task automatic drain(input int budget);
    int k = 0;
    while (!(occupancy_o == '0 && !rd_valid_o && !rd_o && fifo_empty_i) && k < budget) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("drain_done", 32'(k < budget), 32'd1);
    repeat (4) @(posedge clk_i);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_grants;
    int occ_exp;
    int rd_cnt, rd_cyc, val_cyc;
    logic [DW-1:0] val_data;
    int sn;

    set_vec(0,  4'b1111, 4'b0001, 4'b0001);
    set_vec(1,  4'b1111, 4'b0010, 4'b0001);
    set_vec(2,  4'b1111, 4'b0100, 4'b0001);
    set_vec(3,  4'b1111, 4'b1000, 4'b0001);
    set_vec(4,  4'b1111, 4'b0001, 4'b0001);
    set_vec(5,  4'b1111, 4'b0010, 4'b0001);
    set_vec(6,  4'b1111, 4'b0100, 4'b0001);
    set_vec(7,  4'b1111, 4'b1000, 4'b0001);
    set_vec(8,  4'b0101, 4'b0001, 4'b0001);
    set_vec(9,  4'b0101, 4'b0100, 4'b0001);
    set_vec(10, 4'b0101, 4'b0001, 4'b0001);
    set_vec(11, 4'b1010, 4'b0010, 4'b0010);
    set_vec(12, 4'b1010, 4'b1000, 4'b1000);
    set_vec(13, 4'b0000, 4'b0000, 4'b0000);
    set_vec(14, 4'b1000, 4'b1000, 4'b1000);

    for (int k = 0; k < NR; k++) req_data[k] = 16'hA000 + 16'(k);
    rst_i = 1'b1; req_valid_i = 4'b1111; cfg_offset_i = '0; cfg_load_i = 1'b0; rd_ready_i = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_wr", 32'(wr_o), 32'd0);
    chk("rst_rd", 32'(rd_o), 32'd0);
    chk("rst_oe", 32'(oe_o), 32'd0);
    chk("rst_daf", 32'(daf_o), 32'd0);
    chk("rst_data_in", 32'(data_in_o), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
    chk("rst_rd_data", 32'(rd_data_o), 32'd0);
    chk("rst_occ", 32'(occupancy_o), 32'd0);
    chk("rst_busy", 32'(cfg_busy_o), 32'd1);
    rst_i = 1'b0;

    @(posedge clk_i); #1;
    chk("boot_daf", 32'(daf_o), 32'd1);
    chk("boot_offset", 32'(data_in_o), 32'h0010);
    chk("boot_wr", 32'(wr_o), 32'd0);
    chk("boot_busy", 32'(cfg_busy_o), 32'd1);
    chk("boot_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    chk("run_daf", 32'(daf_o), 32'd0);
    chk("run_busy", 32'(cfg_busy_o), 32'd0);

    // Arbitration table
    n_grants = 0;
    for (int i = 0; i < 15; i++) begin
      req_valid_i = tbl[i].valid;
      #1;
      chk($sformatf("arb_ready[%0d]", i), 32'(req_ready_o), 32'(tbl[i].exp_ready));
      if (tbl[i].exp_ready != '0) begin
        exp_q.push_back(16'hA000 + 16'(oh2idx(tbl[i].exp_ready)));
        n_grants++;
      end
      @(posedge clk_i); #1;
      chk($sformatf("arb_wr[%0d]", i), 32'(wr_o), 32'(tbl[i].exp_ready != '0));
      if (tbl[i].exp_ready != '0)
        chk($sformatf("arb_data[%0d]", i), 32'(data_in_o), 32'(16'hA000 + 16'(oh2idx(tbl[i].exp_ready))));
    end
    req_valid_i = '0;
    occ_exp = n_grants - 2;
    #1;
    chk("tbl_occ", 32'(occupancy_o), 32'(occ_exp));
    chk("tbl_skid_valid", 32'(rd_valid_o), 32'd1);
    chk("tbl_skid_head", 32'(rd_data_o), 32'(exp_q[0]));

    // Fill to FIFO_ENTRIES with the skid buffer full (no reads possible)
    @(posedge clk_i); #1;
    for (int i = 0; i < ENT - occ_exp; i++) begin
      req_valid_i = 4'b0100;
      #1;
      if (req_ready_o != 4'b0100) chk("fill_ready", 32'(req_ready_o), 32'h4);
      exp_q.push_back(16'hA002);
      @(posedge clk_i); #1;
    end
    #1;
    chk("full_occ", 32'(occupancy_o), 32'(ENT));
    chk("full_ready", 32'(req_ready_o), 32'd0);
    @(posedge clk_i); #1;
    rd_ready_i = 1'b1;
    #1;
    chk("full_rw_ready", 32'(req_ready_o), 32'd0);
    chk("full_rw_rd", 32'(rd_o), 32'd1);
    @(posedge clk_i); #1;
    rd_ready_i = 1'b0;
    #1;
    chk("reopen_occ", 32'(occupancy_o), 32'(ENT - 1));
    chk("reopen_ready", 32'(req_ready_o), 32'h4);
    exp_q.push_back(16'hA002);
    @(posedge clk_i); #1;
    #1;
    chk("refull_occ", 32'(occupancy_o), 32'(ENT));
    chk("refull_ready", 32'(req_ready_o), 32'd0);
    req_valid_i = '0;
    rd_ready_i  = 1'b1;
    drain(1500);

    // Single-word read latency
    req_data[1] = 16'h1234; req_valid_i = 4'b0010;
    #1;
    chk("lat_ready", 32'(req_ready_o), 32'h2);
    exp_q.push_back(16'h1234);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    rd_cnt = 0; rd_cyc = -1; val_cyc = -1; val_data = '0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (rd_o) begin rd_cnt++; if (rd_cyc < 0) rd_cyc = c; end
      if (rd_valid_o && val_cyc < 0) begin val_cyc = c; val_data = rd_data_o; end
      @(posedge clk_i); #1;
    end
    chk("lat_rd_pulses", 32'(rd_cnt), 32'd1);
    chk("lat_rd_cycle", 32'(rd_cyc), 32'd2);
    chk("lat_valid_delay", 32'(val_cyc - rd_cyc), 32'd2);
    chk("lat_data", 32'(val_data), 32'h1234);

    // Offset reprogramming while requester 1 streams
    sn = 0;
    req_valid_i = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      req_data[1] = 16'hB000 + 16'(sn);
      #1;
      chk("cfg_pre_ready", 32'(req_ready_o), 32'h2);
      exp_q.push_back(16'hB000 + 16'(sn)); sn++;
      @(posedge clk_i); #1;
    end
    req_data[1] = 16'hB000 + 16'(sn); cfg_offset_i = 16'h0040; cfg_load_i = 1'b1;
    #1;
    chk("cfg_load_ready", 32'(req_ready_o), 32'h2);
    exp_q.push_back(16'hB000 + 16'(sn)); sn++;
    @(posedge clk_i); #1;
    req_data[1] = 16'hB000 + 16'(sn); cfg_offset_i = 16'h0077;
    #1;
    chk("drain1_busy", 32'(cfg_busy_o), 32'd1);
    chk("drain1_ready", 32'(req_ready_o), 32'd0);
    chk("drain1_wr", 32'(wr_o), 32'd1);
    chk("drain1_daf", 32'(daf_o), 32'd0);
    @(posedge clk_i); #1;
    cfg_load_i = 1'b0;
    #1;
    chk("drain2_ready", 32'(req_ready_o), 32'd0);
    chk("drain2_wr", 32'(wr_o), 32'd0);
    chk("drain2_daf", 32'(daf_o), 32'd0);
    @(posedge clk_i); #1;
    chk("prog_daf", 32'(daf_o), 32'd1);
    chk("prog_offset", 32'(data_in_o), 32'h0040);
    chk("prog_wr", 32'(wr_o), 32'd0);
    chk("prog_rd", 32'(rd_o), 32'd0);
    chk("prog_ready", 32'(req_ready_o), 32'd0);
    chk("prog_busy", 32'(cfg_busy_o), 32'd1);
    @(posedge clk_i); #1;
    chk("post_daf", 32'(daf_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      req_data[1] = 16'hB000 + 16'(sn);
      #1;
      chk("post_busy", 32'(cfg_busy_o), 32'd0);
      chk("post_ready", 32'(req_ready_o), 32'h2);
      exp_q.push_back(16'hB000 + 16'(sn)); sn++;
      @(posedge clk_i); #1;
    end
    req_valid_i = '0;
    drain(100);

    // Asynchronous reset with data in the skid buffer and the pointer away from 0
    rd_ready_i = 1'b0; req_valid_i = 4'b0010; req_data[1] = 16'hC000;
    repeat (3) @(posedge clk_i);
    #1;
    req_valid_i = '0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("pre_rst_occ", 32'(occupancy_o), 32'd1);
    chk("pre_rst_valid", 32'(rd_valid_o), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_occ", 32'(occupancy_o), 32'd0);
    chk("arst_valid", 32'(rd_valid_o), 32'd0);
    chk("arst_busy", 32'(cfg_busy_o), 32'd1);
    chk("arst_data_in", 32'(data_in_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("reboot_daf", 32'(daf_o), 32'd1);
    chk("reboot_offset", 32'(data_in_o), 32'h0010);
    @(posedge clk_i); #1;
    req_valid_i = 4'b1111;
    #1;
    chk("reboot_ptr", 32'(req_ready_o), 32'h1);
    req_valid_i = '0;
    @(posedge clk_i); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
